// File: rtl/zap_predecode_copro_dispatch.sv
// Coprocessor dispatch stage: routes CDP/MRC/MCR/LDC/STC to one of NUM_CP channels and stalls until done.
// Optional response timeout is built when ZAP_COPRO_TIMEOUT_EN is defined.
module zap_predecode_copro_dispatch #(
   parameter int                  NUM_CP    = 2,
   // Channel 0 is p14 and channel 1 is p15.
   parameter logic [NUM_CP*4-1:0] CP_MAP    = {4'd15, 4'd14},
   parameter logic [NUM_CP-1:0]   USR_ALLOW = '0,
   parameter int                  TIMEOUT   = 256
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [34:0]       i_instruction,
   input  logic              i_valid,
   input  logic              i_cpsr_ff_t,
   input  logic [4:0]        i_cpsr_ff_mode,
   input  logic              i_irq,
   input  logic              i_fiq,
   input  logic              i_clear_from_writeback,
   input  logic              i_data_stall,
   input  logic              i_clear_from_alu,
   input  logic              i_stall_from_shifter,
   input  logic              i_stall_from_issue,
   input  logic              i_pipeline_dav,
   input  logic [NUM_CP-1:0] i_copro_done,
   output logic [34:0]       o_instruction,
   output logic              o_valid,
   output logic              o_irq,
   output logic              o_fiq,
   output logic              o_stall_from_decode,
   output logic [NUM_CP-1:0] o_copro_dav_ff,
   output logic [31:0]       o_copro_word_ff,
   output logic              o_copro_timeout_ff
);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   localparam logic [4:0]  MODE_USR = 5'b10000;
   localparam logic [34:0] ANDNV    = {4'b1111, 31'd0};

   state_t            state_q, state_d;
   logic [NUM_CP-1:0] dav_q, dav_d;
   logic [31:0]       word_q, word_d;
   logic              timeout_d;

   logic              is_cp_fmt;
   logic              usr_mode;
   logic              found;
   logic              allow;
   logic [NUM_CP-1:0] sel_oh;
   logic              match;
   logic              done_sel;
   logic              timeout_hit;

`ifdef ZAP_COPRO_TIMEOUT_EN
   logic [15:0]       cnt_q, cnt_d;
   logic              timeout_q;
`endif

   // Coprocessor-number lookup; the first matching channel wins on duplicates.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      is_cp_fmt = !i_cpsr_ff_t && (i_instruction[34:32] == 3'd0) &&
                  ((i_instruction[27:24] == 4'b1110) || (i_instruction[27:25] == 3'b110));
      usr_mode  = (i_cpsr_ff_mode == MODE_USR);
      found     = 1'b0;
      allow     = 1'b0;
      sel_oh    = '0;
      for (int k = 0; k < NUM_CP; k++) begin
         if (!found && (i_instruction[11:8] == CP_MAP[k*4 +: 4])) begin
            found     = 1'b1;
            sel_oh[k] = 1'b1;
            allow     = !usr_mode || USR_ALLOW[k];
         end
      end
      match = is_cp_fmt && found && allow;
   end

   // dav_q is one-hot on the latched channel, so it doubles as the done mask.
   assign done_sel = |(i_copro_done & dav_q);

`ifdef ZAP_COPRO_TIMEOUT_EN
   assign timeout_hit = (cnt_q == 16'(TIMEOUT - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      o_instruction       = i_instruction;
      o_valid             = i_valid;
      o_irq               = i_irq;
      o_fiq               = i_fiq;
      o_stall_from_decode = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (match) begin
               o_instruction       = ANDNV;
               o_valid             = 1'b0;
               o_irq               = 1'b0;
               o_fiq               = 1'b0;
               o_stall_from_decode = 1'b1;
            end
         end
         S_BUSY: begin
            o_instruction       = '0;
            o_valid             = 1'b0;
            o_irq               = 1'b0;
            o_fiq               = 1'b0;
            o_stall_from_decode = !(done_sel || timeout_hit);
         end
         default: ;
      endcase
   end

   // Next-state values for an enabled (non-held, non-cleared) edge.
   always_comb begin
      state_d   = state_q;
      dav_d     = dav_q;
      word_d    = word_q;
      timeout_d = 1'b0;
`ifdef ZAP_COPRO_TIMEOUT_EN
      cnt_d     = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (match && !i_pipeline_dav) begin
               state_d = S_BUSY;
               dav_d   = sel_oh;
               word_d  = i_instruction[31:0];
`ifdef ZAP_COPRO_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         S_BUSY: begin
            if (done_sel) begin
               state_d = S_IDLE;
               dav_d   = '0;
               word_d  = '0;
            end else if (timeout_hit) begin
               state_d   = S_IDLE;
               dav_d     = '0;
               word_d    = '0;
               timeout_d = 1'b1;
            end else begin
`ifdef ZAP_COPRO_TIMEOUT_EN
               cnt_d = cnt_q + 16'd1;
`endif
            end
         end
         default: begin
            state_d = S_IDLE;
            dav_d   = '0;
            word_d  = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
      if (i_reset || i_clear_from_writeback || (!i_data_stall && i_clear_from_alu)) begin
         state_q <= S_IDLE;
         dav_q   <= '0;
         word_q  <= '0;
`ifdef ZAP_COPRO_TIMEOUT_EN
         cnt_q     <= '0;
         timeout_q <= 1'b0;
`endif
      end else if (i_data_stall || i_stall_from_shifter || i_stall_from_issue) begin
         // Held edge: transaction state persists; the abort pulse still lasts a single cycle.
`ifdef ZAP_COPRO_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         dav_q   <= dav_d;
         word_q  <= word_d;
`ifdef ZAP_COPRO_TIMEOUT_EN
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign o_copro_dav_ff  = dav_q;
   assign o_copro_word_ff = word_q;

`ifdef ZAP_COPRO_TIMEOUT_EN
   assign o_copro_timeout_ff = timeout_q;
`else
   assign o_copro_timeout_ff = 1'b0;
   logic unused_timeout_d;
   assign unused_timeout_d = timeout_d;
`endif

endmodule
